// File: rtl/truncador_saturador_pipe.sv
// truncador_saturador_pipe: two-stage round/saturate/format pipeline that
// selects an OUT_W-bit window from signed filter accumulator samples.
// Stage 1 rounds, and stage 2 saturates and formats into the output
// register. Sticky per-channel saturation flags and a saturating event
// counter are updated as each sample loads into the output register.
module truncador_saturador_pipe #(
  parameter int IN_W       = 29,
  parameter int OUT_W      = 11,
  parameter int LSB_SEL    = 7,
  parameter int OFFSET_BIN = 1,
  parameter int NCH        = 4,
  parameter int CH_W       = 2,
  parameter int SATCNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_data,
  input  logic [CH_W-1:0]     in_ch,
  input  logic                round_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_sat,
  output logic [NCH-1:0]      sat_flags,
  output logic [SATCNT_W-1:0] sat_count,
  input  logic                sat_clr
);

  // Top bit of the kept window; everything from here up to the sign is
  // the sign/guard field that must be uniform for an in-range result.
  localparam int HI = LSB_SEL + OUT_W - 1;

  logic                en;
  logic                load;
  logic                sat_evt;

  logic                s1_valid_q, s1_valid_d;
  logic [IN_W:0]       s1_sum_q, s1_sum_d;
  logic [CH_W-1:0]     s1_ch_q, s1_ch_d;

  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic                out_sat_q, out_sat_d;
  logic [NCH-1:0]      sat_flags_q, sat_flags_d;
  logic [SATCNT_W-1:0] sat_count_q, sat_count_d;

  logic [IN_W:HI]      guard;
  logic                sat;
  logic [OUT_W-1:0]    kept;
  logic [OUT_W-1:0]    fmt;

  // Bits below the window only feed the rounding carry in stage 1.
  logic                unused_low_bits;
  assign unused_low_bits = ^s1_sum_q[LSB_SEL-1:0];

  // Global stall: the whole pipe advances only when the output slot frees.
  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;
  assign load     = en & s1_valid_q;
  assign sat_evt  = load & sat;

  // Stage 1: sign-extend by one bit so the rounding add can never wrap.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_ch_d    = s1_ch_q;
    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d = {in_data[IN_W-1], in_data};
        if (round_en) begin
          s1_sum_d = s1_sum_d + ((IN_W+1)'(1) << (LSB_SEL - 1));
        end
        s1_ch_d = in_ch;
      end
    end
  end

  // Stage 2 datapath: clamp when the guard field is not uniform, then format.
  always_comb begin
    guard = s1_sum_q[IN_W:HI];
    sat   = !((&guard) | ~(|guard));
    kept  = s1_sum_q[HI:LSB_SEL];
    if (sat) begin
      kept = s1_sum_q[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
    fmt = kept;
    if (OFFSET_BIN != 0) begin
      fmt[OUT_W-1] = ~kept[OUT_W-1];
    end
  end

  // Output register: holds its contents whenever the pipe is stalled.
  always_comb begin
    out_valid_d = en ? s1_valid_q : out_valid_q;
    out_data_d  = load ? fmt : out_data_q;
    out_ch_d    = load ? s1_ch_q : out_ch_q;
    out_sat_d   = load ? sat : out_sat_q;
  end

  // Saturation counter: a coincident event beats sat_clr, so it restarts at 1.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end
    if (sat_evt) begin
      if (sat_clr) begin
        sat_count_d = SATCNT_W'(1);
      end else if (sat_count_q != {SATCNT_W{1'b1}}) begin
        sat_count_d = sat_count_q + SATCNT_W'(1);
      end
    end
  end

  // Sticky flags, one per channel; out-of-range tags match no flag.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_flag
      always_comb begin
        sat_flags_d[gi] = (sat_flags_q[gi] & ~sat_clr) |
                          (sat_evt & (s1_ch_q == CH_W'(gi)));
      end
    end
  endgenerate

  // State registers with synchronous active-low reset; in-flight data is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
      sat_flags_q <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_ch_q     <= s1_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_sat_q   <= out_sat_d;
      sat_flags_q <= sat_flags_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_sat   = out_sat_q;
  assign sat_flags = sat_flags_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_truncador_saturador_pipe.sv
// Directed bench for truncador_saturador_pipe: reset, window/saturation
// boundaries, rounding, backpressure ordering, clear priority and a 3-bit
// saturating counter on a second instance.
module tb_truncador_saturador_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] in_data;
  logic [1:0]  in_ch;
  logic        round_en;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [1:0]  out_ch;
  logic        out_sat;
  logic [3:0]  sat_flags;
  logic [15:0] sat_count;
  logic        sat_clr;

  logic        in_ready3;
  logic        out_valid3;
  logic [10:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_sat3;
  logic [3:0]  sat_flags3;
  logic [2:0]  sat_count3;

  int n_assert = 0;
  int n_fail   = 0;

  truncador_saturador_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .round_en(round_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_sat(out_sat), .sat_flags(sat_flags),
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  truncador_saturador_pipe #(.SATCNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_ch(in_ch), .round_en(round_en),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_ch(out_ch3), .out_sat(out_sat3), .sat_flags(sat_flags3),
    .sat_count(sat_count3), .sat_clr(sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample in, wait for it to come out, check latency and contents.
  task automatic send1(input string tag, input logic [28:0] d, input logic [1:0] ch,
                       input logic rnd, input logic [10:0] exp_d, input logic exp_s,
                       input logic clr_at_load);
    int lat;
    in_valid = 1'b1;
    in_data  = d;
    in_ch    = ch;
    round_en = rnd;
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    round_en = ~rnd;
    sat_clr  = clr_at_load;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      sat_clr = 1'b0;
      lat++;
    end
    sat_clr  = 1'b0;
    round_en = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'd2);
    chk({tag, ".data"}, {21'd0, out_data}, {21'd0, exp_d});
    chk({tag, ".ch"}, {30'd0, out_ch}, {30'd0, ch});
    chk({tag, ".sat"}, {31'd0, out_sat}, {31'd0, exp_s});
    tick();
  endtask

  logic [28:0] bp_d   [8] = '{29'h0000080, 29'h0000100, 29'h0020000, 29'h0000180,
                              29'h1FFFFF80, 29'h1FFC0000, 29'h0000200, 29'h001FF80};
  logic [10:0] bp_exp [8] = '{11'h401, 11'h402, 11'h7FF, 11'h403,
                              11'h3FF, 11'h000, 11'h404, 11'h7FF};
  logic        bp_sat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int sent;
    int got;
    int cyc;
    int stalls;
    logic        prev_stalled;
    logic [10:0] prev_data;
    logic [1:0]  prev_ch;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 29'h0020000;
    in_ch     = 2'd1;
    round_en  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;

    // Reset held with valid input: nothing may propagate.
    repeat (3) tick();
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_data", {21'd0, out_data}, 32'd0);
    chk("rst.out_ch", {30'd0, out_ch}, 32'd0);
    chk("rst.out_sat", {31'd0, out_sat}, 32'd0);
    chk("rst.sat_count", {16'd0, sat_count}, 32'd0);
    chk("rst.sat_flags", {28'd0, sat_flags}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Window selection and in-range boundaries.
    send1("zero", 29'h0000000, 2'd0, 1'b0, 11'h400, 1'b0, 1'b0);
    send1("half_pos", 29'h0010000, 2'd0, 1'b0, 11'h600, 1'b0, 1'b0);
    send1("min_inrange", 29'h1FFE0000, 2'd3, 1'b0, 11'h000, 1'b0, 1'b0);
    send1("max_inrange", 29'h001FF80, 2'd2, 1'b0, 11'h7FF, 1'b0, 1'b0);
    chk("inrange.sat_count", {16'd0, sat_count}, 32'd0);
    chk("inrange.sat_flags", {28'd0, sat_flags}, 32'd0);

    // Saturation in both directions.
    send1("pos_sat", 29'h0020000, 2'd1, 1'b0, 11'h7FF, 1'b1, 1'b0);
    chk("pos_sat.flags", {28'd0, sat_flags}, 32'b0010);
    chk("pos_sat.count", {16'd0, sat_count}, 32'd1);
    send1("neg_sat", 29'h1FFC0000, 2'd2, 1'b0, 11'h000, 1'b1, 1'b0);
    chk("neg_sat.flags", {28'd0, sat_flags}, 32'b0110);
    chk("neg_sat.count", {16'd0, sat_count}, 32'd2);

    // Rounding, including overflow into saturation and a negative carry.
    send1("rnd_off", 29'h0000040, 2'd0, 1'b0, 11'h400, 1'b0, 1'b0);
    send1("rnd_on", 29'h0000040, 2'd0, 1'b1, 11'h401, 1'b0, 1'b0);
    send1("rnd_ovf", 29'h001FFC0, 2'd3, 1'b1, 11'h7FF, 1'b1, 1'b0);
    chk("rnd_ovf.flags", {28'd0, sat_flags}, 32'b1110);
    chk("rnd_ovf.count", {16'd0, sat_count}, 32'd3);
    send1("rnd_ovf_off", 29'h001FFC0, 2'd3, 1'b0, 11'h7FF, 1'b0, 1'b0);
    send1("neg_rnd_on", 29'h1FFDFFC0, 2'd0, 1'b1, 11'h000, 1'b0, 1'b0);
    send1("neg_rnd_off", 29'h1FFDFFC0, 2'd0, 1'b0, 11'h000, 1'b1, 1'b0);
    chk("neg_rnd.count", {16'd0, sat_count}, 32'd4);

    // Reset while a sample sits in stage 1: it must never appear.
    in_valid = 1'b1;
    in_data  = 29'h0020000;
    in_ch    = 2'd0;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("midrst.sat_count", {16'd0, sat_count}, 32'd0);

    // Clear coinciding with a saturation load: the event wins.
    send1("pre_clr", 29'h0020000, 2'd1, 1'b0, 11'h7FF, 1'b1, 1'b0);
    chk("pre_clr.count", {16'd0, sat_count}, 32'd1);
    send1("clr_coinc", 29'h1FFC0000, 2'd2, 1'b0, 11'h000, 1'b1, 1'b1);
    chk("clr_coinc.count", {16'd0, sat_count}, 32'd1);
    chk("clr_coinc.flags", {28'd0, sat_flags}, 32'b0100);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("clr.count", {16'd0, sat_count}, 32'd0);
    chk("clr.flags", {28'd0, sat_flags}, 32'd0);

    // Backpressure: 8 back-to-back samples, out_ready low for 5 cycles.
    sent = 0;
    got = 0;
    cyc = 0;
    stalls = 0;
    prev_stalled = 1'b0;
    prev_data = '0;
    prev_ch = '0;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data = bp_d[sent];
        in_ch   = 2'(sent);
      end
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      if (prev_stalled) begin
        chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp.hold_data", {21'd0, out_data}, {21'd0, prev_data});
        chk("bp.hold_ch", {30'd0, out_ch}, {30'd0, prev_ch});
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp.data%0d", got), {21'd0, out_data}, {21'd0, bp_exp[got]});
        chk($sformatf("bp.ch%0d", got), {30'd0, out_ch}, 32'(got % 4));
        chk($sformatf("bp.sat%0d", got), {31'd0, out_sat}, {31'd0, bp_sat[got]});
        got++;
      end
      prev_stalled = out_valid && !out_ready;
      prev_data    = out_data;
      prev_ch      = out_ch;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp.delivered", 32'(got), 32'd8);
    chk("bp.stall_seen", 32'(stalls > 0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp.no_extra", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("bp.count", {16'd0, sat_count}, 32'd2);
    chk("bp.flags", {28'd0, sat_flags}, 32'b0110);

    // Saturating counter: 3-bit instance must stick at 7.
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("cnt3.cleared", {29'd0, sat_count3}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      send1($sformatf("cnt_sat%0d", i), 29'h0020000, 2'(i), 1'b0, 11'h7FF, 1'b1, 1'b0);
    end
    chk("cnt3.sticky", {29'd0, sat_count3}, 32'd7);
    chk("cnt16.count", {16'd0, sat_count}, 32'd10);
    chk("cnt3.flags", {28'd0, sat_flags3}, 32'b1111);
    chk("cnt3.in_ready", {31'd0, in_ready3}, 32'd1);
    chk("cnt3.last_data", {20'd0, out_sat3, out_data3}, {20'd0, 1'b1, 11'h7FF});
    chk("cnt3.last_ch", {29'd0, out_valid3, out_ch3}, {29'd0, 1'b0, 2'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
